dmem_param: RTL and testbench

Parametrised single-port data memory for the microprocessor datapath, succeeding the fixed 8-bit × 256 data memory. It adds configurable width and depth, a hardware clear sweep after reset, a registered read with a valid strobe, a ready flag and out-of-range detection. It sits between the ALU result bus (`address`) and the register-file write-back mux (`ReadD`). The core controls it with `MemRead` and `MemWrite`.

---
 rtl/dmem_param.sv | 136 +++++++++++++
 tb/tb_dmem_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_param.sv
// Parametrised single-port data memory: clear sweep after reset, registered read with valid strobe,
// ready flag and out-of-range error strobe. Optional write-first bypass via DMEM_BYPASS_EN.
module dmem_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] WriteD,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadD,
    output logic              ReadValid,
    output logic              Ready,
    output logic              Err
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    logic              in_range_s;
    logic              run_s;
    logic              rd_req_s;
    logic              any_req_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_data_s;

    // Next-state: the sweep ends on the edge that clears the last word.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == LAST_PTR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // State and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= ST_INIT;
            ptr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Request decode and the single write port shared by the sweep and the core.
    always_comb begin
        in_range_s  = ({1'b0, address} < DEPTH_X);
        run_s       = (state_r == ST_RUN);
        rd_req_s    = run_s && MemRead;
        any_req_s   = run_s && (MemRead || MemWrite);
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = INIT_VAL;
        if (Reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            mem_we_s = 1'b1;
        end else if (MemWrite && in_range_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = address;
            mem_wdata_s = WriteD;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read data selection; out-of-range reads return zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (in_range_s) begin
`ifdef DMEM_BYPASS_EN
            if (MemWrite) begin
                rd_data_s = WriteD;
            end else begin
                rd_data_s = mem_r[address];
            end
`else
            rd_data_s = mem_r[address];
`endif
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Storage array; contents survive reset and are cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered outputs, all aligned to the cycle after the request.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ReadD     <= {DATA_W{1'b0}};
            ReadValid <= 1'b0;
            Ready     <= 1'b0;
            Err       <= 1'b0;
        end else begin
            ReadValid <= rd_req_s;
            Err       <= any_req_s && !in_range_s;
            Ready     <= (state_next_s == ST_RUN);
            if (rd_req_s) begin
                ReadD <= rd_data_s;
            end
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
// Self-checking bench for dmem_param: default instance plus a DEPTH=200 instance sharing stimulus.
module tb_dmem_param;

    logic       clk;
    logic       Reset;
    logic [7:0] address;
    logic [7:0] WriteD;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] rd_d,  rd_d2;
    logic       rv,    rv2;
    logic       rdy,   rdy2;
    logic       err,   err2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    dmem_param dut (
        .clk(clk), .Reset(Reset), .address(address), .WriteD(WriteD),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadD(rd_d), .ReadValid(rv), .Ready(rdy), .Err(err)
    );

    dmem_param #(.DEPTH(200)) dut200 (
        .clk(clk), .Reset(Reset), .address(address), .WriteD(WriteD),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadD(rd_d2), .ReadValid(rv2), .Ready(rdy2), .Err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        address  = 8'h00;
        WriteD   = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (rdy !== 1'b0 || rv !== 1'b0 || err !== 1'b0 || rd_d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b rv=%b err=%b rd=%h, want 0 0 0 00", rdy, rv, err, rd_d);
        end
    endtask

    // Sweep with requests held high for part of it: none may take effect.
    task automatic test_init_sweep();
        int bad_rdy = 0;
        int bad_strobe = 0;
        Reset    = 1'b0;
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        address  = 8'h05;
        WriteD   = 8'hFF;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 150) idle();
            if (i < 256 && rdy !== 1'b0) bad_rdy++;
            if (rv !== 1'b0 || err !== 1'b0) bad_strobe++;
        end
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL sweep_ready_early: Ready high on %0d of 255 sweep edges, want 0", bad_rdy);
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_ready_256: got Ready=%b after 256 edges, want 1", rdy);
        end
        n_checks++;
        if (bad_strobe != 0) begin
            n_fail++;
            $display("FAIL init_strobes: ReadValid/Err high on %0d sweep edges, want 0", bad_strobe);
        end
        // Read back 0..3 and 5: all must hold INIT_VAL.
        for (int a = 0; a < 6; a++) begin
            if (a == 4) continue;
            address = 8'(a);
            MemRead = 1'b1;
            exp_q.push_back(8'h00);
            tick();
            n_checks++;
            exp_v = exp_q.pop_front();
            if (rv !== 1'b1 || rd_d !== exp_v) begin
                n_fail++;
                $display("FAIL init_readback[%0d]: got rv=%b rd=%h, want rv=1 rd=%h", a, rv, rd_d, exp_v);
            end
        end
        idle();
        tick();
        n_checks++;
        if (rv !== 1'b0 || rd_d !== 8'h00) begin
            n_fail++;
            $display("FAIL no_read_hold: got rv=%b rd=%h, want rv=0 rd=00", rv, rd_d);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) begin
            address  = 8'(a);
            WriteD   = 8'h55;
            MemWrite = 1'b1;
            tick();
            n_checks++;
            if (rv !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL write_strobes[%0d]: got rv=%b err=%b, want 0 0", a, rv, err);
            end
        end
        MemWrite = 1'b0;
        for (int a = 0; a < 4; a++) begin
            address = 8'(a);
            MemRead = 1'b1;
            exp_q.push_back(8'h55);
            tick();
            n_checks++;
            exp_v = exp_q.pop_front();
            if (rv !== 1'b1 || rd_d !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got rv=%b rd=%h, want rv=1 rd=%h", a, rv, rd_d, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        address  = 8'h07;
        WriteD   = 8'h11;
        MemWrite = 1'b1;
        tick();
        WriteD  = 8'hA5;
        MemRead = 1'b1;
`ifdef DMEM_BYPASS_EN
        exp_q.push_back(8'hA5);
`else
        exp_q.push_back(8'h11);
`endif
        tick();
        n_checks++;
        exp_v = exp_q.pop_front();
        if (rv !== 1'b1 || rd_d !== exp_v) begin
            n_fail++;
            $display("FAIL rw_same_addr: got rv=%b rd=%h, want rv=1 rd=%h", rv, rd_d, exp_v);
        end
        MemWrite = 1'b0;
        exp_q.push_back(8'hA5);
        tick();
        n_checks++;
        exp_v = exp_q.pop_front();
        if (rv !== 1'b1 || rd_d !== exp_v) begin
            n_fail++;
            $display("FAIL rw_commit: got rv=%b rd=%h, want rv=1 rd=%h", rv, rd_d, exp_v);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        address  = 8'd199;
        WriteD   = 8'h99;
        MemWrite = 1'b1;
        tick();
        n_checks++;
        if (err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_edge_199: got Err=%b, want 0", err2);
        end
        address = 8'd210;
        WriteD  = 8'h3C;
        tick();
        n_checks++;
        if (err2 !== 1'b1 || rv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write: got Err=%b rv=%b, want 1 0", err2, rv2);
        end
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        n_checks++;
        exp_v = exp_q.pop_front();
        if (err2 !== 1'b1 || rv2 !== 1'b1 || rd_d2 !== exp_v) begin
            n_fail++;
            $display("FAIL oor_read: got Err=%b rv=%b rd=%h, want 1 1 %h", err2, rv2, rd_d2, exp_v);
        end
        address = 8'd199;
        exp_q.push_back(8'h99);
        tick();
        n_checks++;
        exp_v = exp_q.pop_front();
        if (err2 !== 1'b0 || rv2 !== 1'b1 || rd_d2 !== exp_v) begin
            n_fail++;
            $display("FAIL oor_neighbour: got Err=%b rv=%b rd=%h, want 0 1 %h", err2, rv2, rd_d2, exp_v);
        end
        idle();
        tick();
        n_checks++;
        if (err2 !== 1'b0 || rv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_strobe_len: got Err=%b rv=%b, want 0 0", err2, rv2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad_rdy = 0;
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        Reset = 1'b1;
        tick();
        n_checks++;
        if (rdy !== 1'b0 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got Ready=%b/%b, want 0/0", rdy, rdy2);
        end
        Reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i < 256 && rdy !== 1'b0) bad_rdy++;
            if (i == 199) begin
                n_checks++;
                if (rdy2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL d200_ready_199: got Ready=%b, want 0", rdy2);
                end
            end
            if (i == 200) begin
                n_checks++;
                if (rdy2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL d200_ready_200: got Ready=%b, want 1", rdy2);
                end
            end
        end
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL mid_sweep_early: Ready high on %0d edges before 256, want 0", bad_rdy);
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_256: got Ready=%b, want 1", rdy);
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        test_reset();
        test_init_sweep();
        test_back_to_back();
        test_simultaneous();
        test_out_of_range();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
